// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between requesters (master) and the round-robin arbiter (slave).
// The lock signal exists only when RR_LOCK_EN is defined.
interface rr_arbiter_if #(
    parameter int ISIZE = 8,
    parameter int PTRW  = (ISIZE > 1) ? $clog2(ISIZE) : 1
);
    logic [ISIZE-1:0] reqs;
    logic             ack;
    logic [ISIZE-1:0] gnts;
    logic             gnt_valid;
    logic [PTRW-1:0]  gnt_idx;
`ifdef RR_LOCK_EN
    logic             lock;

    modport master (
        output reqs,
        output ack,
        output lock,
        input  gnts,
        input  gnt_valid,
        input  gnt_idx
    );

    modport slave (
        input  reqs,
        input  ack,
        input  lock,
        output gnts,
        output gnt_valid,
        output gnt_idx
    );
`else
    modport master (
        output reqs,
        output ack,
        input  gnts,
        input  gnt_valid,
        input  gnt_idx
    );

    modport slave (
        input  reqs,
        input  ack,
        output gnts,
        output gnt_valid,
        output gnt_idx
    );
`endif
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grants, ack/abort handshake and zero-bubble
// back-to-back grants. Optional grant locking is enabled by defining RR_LOCK_EN.
module rr_arbiter #(
    parameter int ISIZE = 8,
    parameter int PTRW  = (ISIZE > 1) ? $clog2(ISIZE) : 1
) (
    input  logic        clk,
    input  logic        rst,
    rr_arbiter_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [PTRW-1:0]  ptr_reg, ptr_next;
    logic [ISIZE-1:0] gnts_reg, gnts_next;
    logic [PTRW-1:0]  gnt_idx_reg, gnt_idx_next;
    logic             gnt_valid_reg;

    logic [PTRW-1:0]    ptr_after;
    logic [PTRW-1:0]    arb_base;
    logic [2*ISIZE-1:0] reqs_dbl;
    logic [2*ISIZE-1:0] reqs_shift;
    logic [ISIZE-1:0]   reqs_rot;
    logic [ISIZE-1:0]   first_rot;
    logic [PTRW-1:0]    off_acc [ISIZE+1];
    logic [PTRW:0]      win_sum;
    logic [PTRW-1:0]    arb_idx;
    logic               arb_found;
    logic [ISIZE-1:0]   arb_onehot;
    logic               cur_req;
    logic               hold;
    logic               grant_end;

    // Pointer one past the current winner; the winner becomes lowest priority.
    assign ptr_after = (gnt_idx_reg == PTRW'(ISIZE - 1)) ? '0 : gnt_idx_reg + 1'b1;
    assign arb_base  = (state_reg == GRANT) ? ptr_after : ptr_reg;

    // Rotate requests so that arb_base lands on bit 0, then isolate the lowest set bit.
    assign reqs_dbl   = {bus.reqs, bus.reqs};
    assign reqs_shift = reqs_dbl >> arb_base;
    assign reqs_rot   = reqs_shift[ISIZE-1:0];
    assign first_rot  = reqs_rot & (~reqs_rot + 1'b1);
    assign arb_found  = |reqs_rot;

    assign off_acc[0] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < ISIZE; gi++) begin : g_offset
            assign off_acc[gi+1] = off_acc[gi] | (first_rot[gi] ? PTRW'(gi) : '0);
        end
    endgenerate

    // Map the rotated offset back to an absolute requester index.
    assign win_sum = {1'b0, arb_base} + {1'b0, off_acc[ISIZE]};
    assign arb_idx = (win_sum >= (PTRW+1)'(ISIZE)) ? PTRW'(win_sum - (PTRW+1)'(ISIZE))
                                                    : win_sum[PTRW-1:0];

    generate
        for (gi = 0; gi < ISIZE; gi++) begin : g_onehot
            assign arb_onehot[gi] = arb_found && (arb_idx == PTRW'(gi));
        end
    endgenerate

    // gnts_reg is one-hot on the current winner, so this is reqs[w] without an index.
    assign cur_req = |(bus.reqs & gnts_reg);

`ifdef RR_LOCK_EN
    assign hold = bus.lock && bus.ack && cur_req;
`else
    assign hold = 1'b0;
`endif

    // An abort (request dropped) is an end even if ack is also high; lock never blocks it.
    assign grant_end = (bus.ack || !cur_req) && !hold;

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        gnts_next    = gnts_reg;
        gnt_idx_next = gnt_idx_reg;
        unique case (state_reg)
            IDLE: begin
                if (arb_found) begin
                    state_next   = GRANT;
                    gnts_next    = arb_onehot;
                    gnt_idx_next = arb_idx;
                end
            end
            GRANT: begin
                if (grant_end) begin
                    ptr_next = ptr_after;
                    if (arb_found) begin
                        gnts_next    = arb_onehot;
                        gnt_idx_next = arb_idx;
                    end else begin
                        state_next   = IDLE;
                        gnts_next    = '0;
                        gnt_idx_next = '0;
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                gnts_next    = '0;
                gnt_idx_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            gnts_reg      <= '0;
            gnt_idx_reg   <= '0;
            gnt_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            gnts_reg      <= gnts_next;
            gnt_idx_reg   <= gnt_idx_next;
            gnt_valid_reg <= |gnts_next;
        end
    end

    assign bus.gnts      = gnts_reg;
    assign bus.gnt_valid = gnt_valid_reg;
    assign bus.gnt_idx   = gnt_idx_reg;

    onehot_grant: assert property (@(posedge clk) disable iff (rst) $onehot0(gnts_reg));

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter: directed scenarios plus randomized traffic,
// all compared against an index/pointer reference model.
module tb_rr_arbiter;
    localparam int ISIZE = 8;
    localparam int PTRW  = 3;
`ifdef RR_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;

    // Reference model: round-robin pointer and current winner (-1 = idle).
    int m_ptr = 0;
    int m_gnt = -1;

    rr_arbiter_if #(.ISIZE(ISIZE)) bus ();

    rr_arbiter #(.ISIZE(ISIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    function automatic int m_search(logic [ISIZE-1:0] r, int base);
        for (int k = 0; k < ISIZE; k++) begin
            int idx;
            idx = (base + k) % ISIZE;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_update(input logic [ISIZE-1:0] r, input logic a, input logic l,
                                input logic rs);
        bit ended;
        if (rs) begin
            m_ptr = 0;
            m_gnt = -1;
        end else if (m_gnt < 0) begin
            m_gnt = m_search(r, m_ptr);
        end else begin
            ended = a || !r[m_gnt];
            if (LOCK_EN && a && l && r[m_gnt]) ended = 1'b0;
            if (ended) begin
                m_ptr = (m_gnt + 1) % ISIZE;
                m_gnt = m_search(r, m_ptr);
            end
        end
    endtask

    function automatic logic [ISIZE+PTRW:0] exp_vec();
        logic [ISIZE-1:0] g;
        logic [PTRW-1:0]  ix;
        g  = '0;
        ix = '0;
        if (m_gnt >= 0) begin
            g[m_gnt] = 1'b1;
            ix = PTRW'(m_gnt);
        end
        return {g, (m_gnt >= 0), ix};
    endfunction

    task automatic step(input logic [ISIZE-1:0] r, input logic a, input logic l, input logic rs);
        bus.reqs = r;
        bus.ack  = a;
`ifdef RR_LOCK_EN
        bus.lock = l;
`endif
        rst = rs;
        @(posedge clk);
        model_update(r, a, l, rs);
        #1;
        cyc++;
        $display("cyc %0d rst=%0b reqs=%h ack=%0b lock=%0b -> gnts=%h valid=%0b idx=%0d",
                 cyc, rs, r, a, l, bus.gnts, bus.gnt_valid, bus.gnt_idx);
    endtask

    task automatic do_reset();
        step('0, 1'b0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(8'hFF, 1'b0, 1'b0, 1'b1);
            n_checks++;
            if ({bus.gnts, bus.gnt_valid, bus.gnt_idx} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: got gnts=%h valid=%0b idx=%0d, want all zero",
                         bus.gnts, bus.gnt_valid, bus.gnt_idx);
            end
        end
    endtask

    task automatic test_single_hold();
        do_reset();
        step(8'h04, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (bus.gnts !== 8'h04 || bus.gnt_idx !== 3'd2 || bus.gnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_first: got gnts=%h idx=%0d, want gnts=04 idx=2",
                     bus.gnts, bus.gnt_idx);
        end
        for (int i = 0; i < 3; i++) begin
            step(8'h04, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (bus.gnts !== 8'h04) begin
                n_fail++;
                $display("FAIL single_hold: got gnts=%h, want 04", bus.gnts);
            end
        end
        step(8'h04, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (bus.gnts !== 8'h04 || bus.gnt_idx !== 3'd2 ||
            {bus.gnts, bus.gnt_valid, bus.gnt_idx} !== exp_vec()) begin
            n_fail++;
            $display("FAIL single_regrant: got gnts=%h idx=%0d, want gnts=04 idx=2",
                     bus.gnts, bus.gnt_idx);
        end
    endtask

    task automatic test_back_to_back();
        logic [ISIZE-1:0] rot_exp [9];
        rot_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(8'hFF, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (bus.gnts !== rot_exp[i] || {bus.gnts, bus.gnt_valid, bus.gnt_idx} !== exp_vec()) begin
                n_fail++;
                $display("FAIL rotation[%0d]: got gnts=%h idx=%0d, want gnts=%h",
                         i, bus.gnts, bus.gnt_idx, rot_exp[i]);
            end
        end
    endtask

    task automatic test_abort();
        do_reset();
        step(8'h03, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (bus.gnts !== 8'h01) begin
            n_fail++;
            $display("FAIL abort_first: got gnts=%h, want 01", bus.gnts);
        end
        step(8'h02, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (bus.gnts !== 8'h02 || bus.gnt_idx !== 3'd1) begin
            n_fail++;
            $display("FAIL abort_switch: got gnts=%h idx=%0d, want gnts=02 idx=1",
                     bus.gnts, bus.gnt_idx);
        end
        step(8'h00, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({bus.gnts, bus.gnt_valid, bus.gnt_idx} !== '0) begin
            n_fail++;
            $display("FAIL abort_idle: got gnts=%h valid=%0b idx=%0d, want all zero",
                     bus.gnts, bus.gnt_valid, bus.gnt_idx);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        step(8'h20, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (bus.gnts !== 8'h20 || bus.gnt_idx !== 3'd5) begin
            n_fail++;
            $display("FAIL midrst_grant: got gnts=%h idx=%0d, want gnts=20 idx=5",
                     bus.gnts, bus.gnt_idx);
        end
        step(8'hFF, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if ({bus.gnts, bus.gnt_valid, bus.gnt_idx} !== '0) begin
            n_fail++;
            $display("FAIL midrst_clear: got gnts=%h valid=%0b, want zero",
                     bus.gnts, bus.gnt_valid);
        end
        step(8'hFF, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (bus.gnts !== 8'h01 || bus.gnt_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL midrst_restart: got gnts=%h, want 01", bus.gnts);
        end
    endtask

`ifdef RR_LOCK_EN
    task automatic test_lock();
        do_reset();
        step(8'hFF, 1'b0, 1'b0, 1'b0);
        step(8'hFF, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (bus.gnts !== 8'h01) begin
            n_fail++;
            $display("FAIL lock_hold: got gnts=%h, want 01", bus.gnts);
        end
        step(8'hFF, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (bus.gnts !== 8'h02) begin
            n_fail++;
            $display("FAIL lock_release: got gnts=%h, want 02", bus.gnts);
        end
        do_reset();
        step(8'hFF, 1'b0, 1'b0, 1'b0);
        step(8'hFE, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (bus.gnts !== 8'h02) begin
            n_fail++;
            $display("FAIL lock_abort: got gnts=%h, want 02", bus.gnts);
        end
    endtask
`endif

    task automatic test_random();
        logic [ISIZE-1:0] r;
        logic a, l, rs;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 3) == 0) ? ISIZE'($urandom) & ISIZE'($urandom)
                                               : ISIZE'($urandom);
            a  = ($urandom_range(0, 2) == 0);
            l  = ($urandom_range(0, 1) == 0);
            rs = ($urandom_range(0, 49) == 0);
            step(r, a, l, rs);
            n_checks++;
            if ({bus.gnts, bus.gnt_valid, bus.gnt_idx} !== exp_vec() || !$onehot0(bus.gnts)) begin
                n_fail++;
                $display("FAIL random[%0d]: got gnts=%h valid=%0b idx=%0d, want {gnts,valid,idx}=%h",
                         i, bus.gnts, bus.gnt_valid, bus.gnt_idx, exp_vec());
            end
        end
    endtask

    initial begin
        bus.reqs = '0;
        bus.ack  = 1'b0;
`ifdef RR_LOCK_EN
        bus.lock = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_single_hold();
        test_back_to_back();
        test_abort();
        test_reset_mid_grant();
`ifdef RR_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
